// File: rtl/md_issue.sv
// Issue/stall controller placed in front of the multiply/divide unit.
// It sends one start pulse per op and holds EX until the unit has settled.
module md_issue #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic             flush,
  input  logic             xalu_busy,
  output logic [3:0]       xalu_op,
  output logic             xalu_start,
  output logic [31:0]      xalu_d1,
  output logic [31:0]      xalu_d2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned OP_W = 4;
  localparam int unsigned D_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OP_W-1:0] r_op;
  logic            w_is_wr;
  logic            w_is_rd;
  logic            w_md;
  logic            w_accept;
  logic            w_stall;
  logic [OP_W-1:0] w_xalu_op;

  // Op classes: writes start the unit, reads only need HI/LO to be settled.
  always_comb begin
    w_is_wr = 1'b0;
    w_is_rd = 1'b0;
    case (in_op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: w_is_wr = 1'b1;
      4'd5, 4'd6:                         w_is_rd = 1'b1;
      default: ;
    endcase
  end

  assign w_md = in_valid && (w_is_wr || w_is_rd) && !flush;

  // Next state and combinational outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xalu_op   = '0;
    w_stall     = w_md && ((r_state != S_IDLE) || xalu_busy);
    case (r_state)
      S_IDLE: begin
        if (w_md && w_is_wr && !xalu_busy) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
        if (w_md && w_is_rd && !xalu_busy) begin
          w_xalu_op = in_op;
        end
      end
      S_ISSUE: begin
        w_xalu_op   = r_op;
        w_state_nxt = S_SETTLE;
      end
      // Busy becomes visible here; mthi/mtlo and div-by-zero never raise it.
      S_SETTLE: begin
        w_state_nxt = xalu_busy ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!xalu_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Held at zero while reset is asserted, even if the unit reports busy.
  assign stall   = reset && w_stall;
  assign xalu_op = reset ? w_xalu_op : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Op and operand capture; the start pulse lines up with ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= '0;
      xalu_start <= 1'b0;
      xalu_d1    <= '0;
      xalu_d2    <= '0;
    end else begin
      xalu_start <= w_accept;
      if (w_accept) begin
        r_op    <= in_op;
        xalu_d1 <= D_W'(in_rs);
        xalu_d2 <= D_W'(in_rt);
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      op_count    <= '0;
    end else begin
      if (w_stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if ((r_state == S_ISSUE) && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue with a small behavioural MD unit attached
// (mult 5 busy cycles, div 10, div-by-zero and mthi/mtlo never busy).
module tb_md_issue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic        flush;

  logic        m_busy;
  logic [3:0]  m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_out;

  logic [3:0]  xalu_op;
  logic        xalu_start;
  logic [31:0] xalu_d1;
  logic [31:0] xalu_d2;
  logic        stall;
  logic [31:0] stall_count;
  logic [31:0] op_count;

  logic [3:0]  s_xalu_op;
  logic        s_xalu_start;
  logic [31:0] s_xalu_d1;
  logic [31:0] s_xalu_d2;
  logic        s_stall;
  logic [3:0]  s_stall_count;
  logic [3:0]  s_op_count;

  int n_asrt;
  int n_fail;

  md_issue #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .flush(flush), .xalu_busy(m_busy),
    .xalu_op(xalu_op), .xalu_start(xalu_start), .xalu_d1(xalu_d1),
    .xalu_d2(xalu_d2), .stall(stall), .stall_count(stall_count),
    .op_count(op_count)
  );

  md_issue #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .flush(flush), .xalu_busy(m_busy),
    .xalu_op(s_xalu_op), .xalu_start(s_xalu_start), .xalu_d1(s_xalu_d1),
    .xalu_d2(s_xalu_d2), .stall(s_stall), .stall_count(s_stall_count),
    .op_count(s_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MD unit, driven by the 32-bit instance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (xalu_start) begin
      case (xalu_op)
        4'd1: begin
          {m_hi, m_lo} <= 64'(longint'($signed(xalu_d1)) * longint'($signed(xalu_d2)));
          m_busy <= 1'b1; m_cnt <= 4'd5;
        end
        4'd2: begin
          {m_hi, m_lo} <= 64'({32'd0, xalu_d1}) * 64'({32'd0, xalu_d2});
          m_busy <= 1'b1; m_cnt <= 4'd5;
        end
        4'd3: m_hi <= xalu_d1;
        4'd4: m_lo <= xalu_d1;
        4'd7: if (xalu_d2 != 32'd0) begin
          m_lo <= 32'($signed(xalu_d1) / $signed(xalu_d2));
          m_hi <= 32'($signed(xalu_d1) % $signed(xalu_d2));
          m_busy <= 1'b1; m_cnt <= 4'd10;
        end
        4'd8: if (xalu_d2 != 32'd0) begin
          m_lo <= xalu_d1 / xalu_d2;
          m_hi <= xalu_d1 % xalu_d2;
          m_busy <= 1'b1; m_cnt <= 4'd10;
        end
        default: ;
      endcase
    end else if (m_cnt != 4'd0) begin
      m_cnt  <= m_cnt - 4'd1;
      m_busy <= (m_cnt > 4'd1);
    end
  end

  assign m_out = (xalu_op == 4'd5) ? m_hi : (xalu_op == 4'd6) ? m_lo : 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one EX-stage cycle after the falling edge; checks follow at +1.
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    @(negedge clk);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; flush = fl;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_asrt = 0; n_fail = 0;
    reset = 1'b0; in_valid = 1'b1; in_op = 4'd5; in_rs = '0; in_rt = '0; flush = 1'b0;
    #3;
    chk("rst_start", 64'(xalu_start), 64'd0);
    chk("rst_d1", 64'(xalu_d1), 64'd0);
    chk("rst_d2", 64'(xalu_d2), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_op", 64'(xalu_op), 64'd0);
    chk("rst_scnt", 64'(stall_count), 64'd0);
    chk("rst_ocnt", 64'(op_count), 64'd0);
    @(negedge clk); in_valid = 1'b0; in_op = 4'd0;
    @(negedge clk); reset = 1'b1;

    // mult 3 * -2, then mflo
    drive(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
    chk("t1_c0_stall", 64'(stall), 64'd0);
    chk("t1_c0_op", 64'(xalu_op), 64'd0);
    drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    chk("t1_c1_start", 64'(xalu_start), 64'd1);
    chk("t1_c1_op", 64'(xalu_op), 64'd1);
    chk("t1_c1_d1", 64'(xalu_d1), 64'd3);
    chk("t1_c1_d2", 64'(xalu_d2), 64'hFFFF_FFFE);
    chk("t1_c1_stall", 64'(stall), 64'd1);
    for (int c = 2; c <= 7; c++) begin
      drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
      chk($sformatf("t1_c%0d_stall", c), 64'(stall), 64'd1);
      chk($sformatf("t1_c%0d_start", c), 64'(xalu_start), 64'd0);
    end
    drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    chk("t1_c8_stall", 64'(stall), 64'd0);
    chk("t1_c8_op", 64'(xalu_op), 64'd6);
    chk("t1_c8_out", 64'(m_out), 64'hFFFF_FFFA);
    chk("t1_scnt", 64'(stall_count), 64'd7);
    chk("t1_ocnt", 64'(op_count), 64'd1);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    // div 5/0, then mfhi: HI stays 0xFFFFFFFF from the mult
    drive(1'b1, 4'd7, 32'd5, 32'd0, 1'b0);
    chk("t2_c0_stall", 64'(stall), 64'd0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("t2_c1_stall", 64'(stall), 64'd1);
    chk("t2_c1_start", 64'(xalu_start), 64'd1);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("t2_c2_stall", 64'(stall), 64'd1);
    chk("t2_c2_busy", 64'(m_busy), 64'd0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("t2_c3_stall", 64'(stall), 64'd0);
    chk("t2_c3_op", 64'(xalu_op), 64'd5);
    chk("t2_c3_out", 64'(m_out), 64'hFFFF_FFFF);
    chk("t2_scnt", 64'(stall_count), 64'd9);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    // mthi then mtlo back-to-back
    drive(1'b1, 4'd3, 32'h1234, 32'd0, 1'b0);
    chk("t3_c0_stall", 64'(stall), 64'd0);
    drive(1'b1, 4'd4, 32'h5678, 32'd0, 1'b0);
    chk("t3_c1_stall", 64'(stall), 64'd1);
    chk("t3_c1_d1", 64'(xalu_d1), 64'h1234);
    drive(1'b1, 4'd4, 32'h5678, 32'd0, 1'b0);
    chk("t3_c2_stall", 64'(stall), 64'd1);
    drive(1'b1, 4'd4, 32'h5678, 32'd0, 1'b0);
    chk("t3_c3_stall", 64'(stall), 64'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("t3_c4_start", 64'(xalu_start), 64'd1);
    chk("t3_c4_op", 64'(xalu_op), 64'd4);
    chk("t3_c4_d1", 64'(xalu_d1), 64'h5678);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("t3_hi", 64'(m_out), 64'h1234);
    drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    chk("t3_lo", 64'(m_out), 64'h5678);
    chk("t3_ocnt", 64'(op_count), 64'd4);
    chk("t3_scnt", 64'(stall_count), 64'd11);

    // flushed div and an unused op code
    drive(1'b1, 4'd7, 32'd9, 32'd3, 1'b1);
    chk("t4_stall", 64'(stall), 64'd0);
    drive(1'b1, 4'd12, 32'd9, 32'd3, 1'b0);
    chk("t4_start", 64'(xalu_start), 64'd0);
    chk("t4_bad_stall", 64'(stall), 64'd0);
    chk("t4_bad_op", 64'(xalu_op), 64'd0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("t4_bad_start", 64'(xalu_start), 64'd0);
    chk("t4_idle_op", 64'(xalu_op), 64'd5);
    chk("t4_idle_stall", 64'(stall), 64'd0);
    chk("t4_ocnt", 64'(op_count), 64'd4);

    // reset asserted while waiting on divu 100/7
    drive(1'b1, 4'd8, 32'd100, 32'd7, 1'b0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    chk("t5_wait_stall", 64'(stall), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_start", 64'(xalu_start), 64'd0);
    chk("t5_stall", 64'(stall), 64'd0);
    chk("t5_op", 64'(xalu_op), 64'd0);
    chk("t5_scnt", 64'(stall_count), 64'd0);
    chk("t5_ocnt", 64'(op_count), 64'd0);
    @(negedge clk); reset = 1'b1;
    drive(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
    chk("t5_re_stall", 64'(stall), 64'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("t5_re_start", 64'(xalu_start), 64'd1);
    chk("t5_re_d1", 64'(xalu_d1), 64'd2);
    for (int c = 0; c < 8; c++) drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("t5_re_ocnt", 64'(op_count), 64'd1);

    // three mult/mflo pairs, 21 stall cycles in total
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 4'd1, 32'(k), 32'd5, 1'b0);
      for (int c = 0; c < 8; c++) drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
      chk($sformatf("t6_out%0d", k), 64'(m_out), 64'(5 * k));
      drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    end
    chk("t6_scnt32", 64'(stall_count), 64'd21);
    chk("t6_scnt4", 64'(s_stall_count), 64'd15);
    chk("t6_ocnt4", 64'(s_op_count), 64'd4);
    chk("t6_ocnt32", 64'(op_count), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/md_issue.md
Name: md_issue

Overview:
- Issue and stall controller in the EX stage, directly upstream of the multiply/divide unit (xalu).
- Accepts decoded MD-class instructions and their operands from the pipeline.
- Issues one registered start pulse per op and holds the pipeline on structural and HI/LO hazards until the unit has settled.
- Masks the one-cycle gap before the unit's Busy becomes visible, and handles the div-by-zero case, where Busy never rises.

Parameters:
- CNT_W, 32: width of the saturating performance counters stall_count and op_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  EX-stage instruction valid
- in_op  in  4  MD op code: 0 none, 1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu, 9-15 treated as 0
- in_rs  in  32  operand 1 (forwarded rs)
- in_rt  in  32  operand 2 (forwarded rt)
- flush  in  1  kill the EX-stage instruction this cycle
- xalu_busy  in  1  Busy from the MD unit
- xalu_op  out  4  XALUOp to the MD unit
- xalu_start  out  1  Start to the MD unit, registered
- xalu_d1  out  32  D1, registered
- xalu_d2  out  32  D2, registered
- stall  out  1  freeze IF/ID/EX, combinational
- stall_count  out  CNT_W  cycles with stall=1, saturating
- op_count  out  CNT_W  ops issued (start pulses), saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; xalu_start, xalu_d1, xalu_d2, stall_count and op_count all 0.
  - xalu_op=0 and stall=0 while reset is held.
- Classes:
  - write ops W = {1,2,3,4,7,8}
  - read ops R = {5,6}
  - md = in_valid && in_op in W∪R && !flush
- State machine:
  - IDLE:
    - If md && op in W && !xalu_busy: latch op into op_r, latch in_rs/in_rt into xalu_d1/xalu_d2, go to ISSUE. stall=0, so the instruction leaves EX.
    - Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - xalu_start=1, xalu_op=op_r, op_count increments.
    - Always go to SETTLE. Busy is not yet visible this cycle.
  - SETTLE (exactly 1 cycle):
    - If xalu_busy=1, go to WAIT; else go to IDLE.
    - The else branch covers mthi/mtlo and div/divu with D2=0.
  - WAIT: stay while xalu_busy=1; go to IDLE on the first cycle it is sampled 0.
- stall = md && (state!=IDLE || xalu_busy).
  - xalu_busy=1 while in IDLE (unit busy from an earlier context) also stalls.
- xalu_op:
  - op_r in ISSUE.
  - in_op when state=IDLE && md && in_op in R && !xalu_busy, so XALU_Out is valid the same cycle.
  - 0 otherwise.
- xalu_start is 0 outside ISSUE. xalu_d1/xalu_d2 hold their value until the next accept.
- flush:
  - Suppresses accept and stall only for the current EX instruction.
  - Never cancels an op already in ISSUE/SETTLE/WAIT; that op is committed.
- Counters: stall_count increments every cycle stall=1. Both counters saturate at all-ones and never wrap.
- Ops 0 and 9-15: never stall, never issue.
- Reset asserted mid-operation: immediate return to IDLE; the MD unit is reset by the same signal.

Test Plan:
1. mult, in_rs=3, in_rt=0xFFFFFFFE accepted at cycle 0 with the real MD unit attached; mflo presented from cycle 1:
   - cycle 1: xalu_start=1, xalu_d2=0xFFFFFFFE.
   - stall=1 cycles 1-7.
   - cycle 8: stall=0, xalu_op=6, XALU_Out=0xFFFFFFFA.
   - stall_count=7, op_count=1.
2. div, in_rs=5, in_rt=0, followed by mfhi:
   - Busy never rises; SETTLE→IDLE.
   - mfhi stalled cycles 1-2, released cycle 3 with HI unchanged.
   - stall_count=2.
3. mthi 0x1234 then mtlo 0x5678 back-to-back:
   - mtlo stalled 2 cycles, start pulse at cycle 4.
   - HI=0x1234, LO=0x5678.
   - op_count=2.
4. flush=1 with in_valid=1, op=7 in IDLE: no start pulse, stall=0, op_count stays 0, state stays IDLE.
5. reset driven low during WAIT of a divu: state=IDLE, xalu_start=0, stall=0 and counters 0 without a clock edge; normal issue resumes after release.
6. CNT_W=4, a mult issued with a following mflo stalled repeatedly for 20 cumulative stall cycles: stall_count holds 15 (no wrap).
